// File: rtl/clk_divider_bank_if.sv
// clk_divider_bank_if: control and output bundle for the divider bank.
// master drives ena/sync/ch_en/load/div_val; slave returns tick/clk/pend.
interface clk_divider_bank_if #(
  parameter int WIDTH    = 16,
  parameter int CHANNELS = 4
);
  logic                      ena;
  logic                      sync;
  logic [CHANNELS-1:0]       ch_en;
  logic [CHANNELS-1:0]       load;
  logic [CHANNELS*WIDTH-1:0] div_val;
  logic [CHANNELS-1:0]       tick_o;
  logic [CHANNELS-1:0]       clk_o;
  logic [CHANNELS-1:0]       pend_o;

  modport master (
    output ena, sync, ch_en, load, div_val,
    input  tick_o, clk_o, pend_o
  );

  modport slave (
    input  ena, sync, ch_en, load, div_val,
    output tick_o, clk_o, pend_o
  );
endinterface

// File: rtl/clk_divider_bank.sv
// clk_divider_bank: CHANNELS terminal-count dividers, double-buffered ratio.
// Ports: clk, nrst (async low), bus (slave): ena/sync/ch_en/load/div_val in; tick_o/clk_o/pend_o out.
module clk_divider_bank #(
  parameter int WIDTH     = 16,
  parameter int CHANNELS  = 4,
  parameter int RESET_DIV = 1
) (
  input logic               clk,
  input logic               nrst,
  clk_divider_bank_if.slave bus
);

  localparam logic [WIDTH-1:0] RDIV = WIDTH'(RESET_DIV);
  localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);

  logic [WIDTH-1:0]    cnt [CHANNELS];
  logic [WIDTH-1:0]    act [CHANNELS];
  logic [WIDTH-1:0]    pnd [CHANNELS];
  logic [CHANNELS-1:0] pend_q;
  logic [CHANNELS-1:0] clk_q;
  logic [CHANNELS-1:0] tick_q;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      for (int i = 0; i < CHANNELS; i++) begin
        cnt[i] <= '0;
        act[i] <= RDIV;
        pnd[i] <= RDIV;
      end
      pend_q <= '0;
      clk_q  <= '0;
      tick_q <= '0;
    end else begin
      for (int i = 0; i < CHANNELS; i++) begin
        if (bus.ena) begin
          if (bus.sync || !bus.ch_en[i]) begin
            cnt[i]    <= '0;
            clk_q[i]  <= 1'b0;
            tick_q[i] <= 1'b0;
            if (pend_q[i]) begin
              act[i]    <= pnd[i];
              pend_q[i] <= 1'b0;
            end
          end else if (cnt[i] == act[i]) begin
            cnt[i]    <= '0;
            tick_q[i] <= 1'b1;
            clk_q[i]  <= ~clk_q[i];
            if (pend_q[i]) begin
              act[i]    <= pnd[i];
              pend_q[i] <= 1'b0;
            end
          end else begin
            cnt[i]    <= cnt[i] + ONE;
            tick_q[i] <= 1'b0;
          end
        end else begin
          tick_q[i] <= 1'b0;
        end
        // capture last so a same-edge load re-arms pend after a swap
        if (bus.load[i]) begin
          pnd[i]    <= bus.div_val[i*WIDTH +: WIDTH];
          pend_q[i] <= 1'b1;
        end
      end
    end
  end

  assign bus.tick_o = tick_q;
  assign bus.clk_o  = clk_q;
  assign bus.pend_o = pend_q;

endmodule

// File: tb/tb_clk_divider_bank.sv
// tb_clk_divider_bank: directed checks of the divider bank.
// Covers reset, free-run, reload, gating, sync, extremes, ch_en toggle.
module tb_clk_divider_bank;

  logic clk;
  logic nrst;
  int   checks;
  int   errors;

  clk_divider_bank_if #(.WIDTH(16), .CHANNELS(4)) b0 ();
  clk_divider_bank_if #(.WIDTH(4),  .CHANNELS(1)) b1 ();

  clk_divider_bank #(
    .WIDTH(16), .CHANNELS(4), .RESET_DIV(1)
  ) u0 (
    .clk(clk), .nrst(nrst), .bus(b0)
  );

  clk_divider_bank #(
    .WIDTH(4), .CHANNELS(1), .RESET_DIV(15)
  ) u1 (
    .clk(clk), .nrst(nrst), .bus(b1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h at %0t", tag, got, exp, $time);
    end
  endtask

  logic [63:0] et;
  logic [63:0] ep;
  logic        ec;

  initial begin
    checks = 0;
    errors = 0;
    nrst = 1'b0;
    b0.ena = 1'b1; b0.sync = 1'b0; b0.ch_en = 4'hF;
    b0.load = '0;  b0.div_val = '0;
    b1.ena = 1'b0; b1.sync = 1'b0; b1.ch_en = 1'b1;
    b1.load = '0;  b1.div_val = '0;

    repeat (3) @(negedge clk);
    chk("rst_tick", b0.tick_o, 4'h0);
    chk("rst_clk",  b0.clk_o,  4'h0);
    chk("rst_pend", b0.pend_o, 4'h0);
    chk("rst_clk1", b1.clk_o,  1'b0);
    nrst = 1'b1;

    // free run at N=1
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      chk("fr_tick", b0.tick_o, (k % 2 == 0) ? 4'hF : 4'h0);
      chk("fr_clk",  b0.clk_o,  ((k >> 1) & 1) ? 4'hF : 4'h0);
    end

    // ch0 to N=3, aligned by sync
    b0.load = 4'b0001; b0.div_val[15:0] = 16'd3;
    @(negedge clk);
    chk("pre_pend", b0.pend_o[0], 1'b1);
    b0.load = '0; b0.sync = 1'b1;
    @(negedge clk);
    chk("pre_pend0", b0.pend_o[0], 1'b0);
    chk("pre_clk",   b0.clk_o, 4'h0);
    chk("pre_tick",  b0.tick_o, 4'h0);
    b0.sync = 1'b0;

    // reload, same-edge load, gating with ignored sync
    et = '0;
    et[4] = 1'b1;  et[10] = 1'b1; et[16] = 1'b1; et[22] = 1'b1;
    et[28] = 1'b1; et[31] = 1'b1; et[34] = 1'b1; et[44] = 1'b1;
    ep = '0;
    ep[2] = 1'b1; ep[3] = 1'b1;
    for (int k = 22; k <= 27; k++) ep[k] = 1'b1;
    ec = 1'b0;
    for (int k = 1; k <= 44; k++) begin
      b0.load = '0;
      if (k == 2) begin
        b0.load[0] = 1'b1; b0.div_val[15:0] = 16'd5;
      end
      if (k == 22) begin
        b0.load[0] = 1'b1; b0.div_val[15:0] = 16'd2;
      end
      b0.ena  = !(k >= 36 && k <= 42);
      b0.sync = (k == 39);
      @(negedge clk);
      if (et[k]) ec = ~ec;
      chk("rl_tick", b0.tick_o[0], et[k]);
      chk("rl_clk",  b0.clk_o[0],  ec);
      chk("rl_pend", b0.pend_o[0], ep[k]);
    end
    b0.load = '0; b0.sync = 1'b0; b0.ena = 1'b1;

    // phase align ch0 N=2, ch1 N=5
    b0.load = 4'b0010; b0.div_val[31:16] = 16'd5;
    @(negedge clk);
    b0.load = '0;
    repeat (5) @(negedge clk);
    b0.sync = 1'b1;
    @(negedge clk);
    b0.sync = 1'b0;
    chk("sy_clk",  b0.clk_o[1:0],  2'b00);
    chk("sy_tick", b0.tick_o[1:0], 2'b00);
    chk("sy_pend", b0.pend_o[1],   1'b0);
    for (int j = 1; j <= 12; j++) begin
      @(negedge clk);
      chk("sy_t0", b0.tick_o[0], (j % 3 == 0));
      chk("sy_t1", b0.tick_o[1], (j % 6 == 0));
      chk("sy_c0", b0.clk_o[0],  ((j / 3) % 2 == 1));
      chk("sy_c1", b0.clk_o[1],  ((j / 6) % 2 == 1));
    end

    // N=0 on ch2, then ena drop forces tick low
    b0.load = 4'b0100; b0.div_val[47:32] = 16'd0;
    @(negedge clk);
    b0.load = '0; b0.sync = 1'b1;
    @(negedge clk);
    b0.sync = 1'b0;
    chk("n0_clk",  b0.clk_o[2],  1'b0);
    chk("n0_pend", b0.pend_o[2], 1'b0);
    for (int j = 1; j <= 5; j++) begin
      @(negedge clk);
      chk("n0_tick", b0.tick_o[2], 1'b1);
      chk("n0_clkd", b0.clk_o[2],  j[0]);
    end
    b0.ena = 1'b0;
    @(negedge clk);
    chk("gt_tick", b0.tick_o[2], 1'b0);
    chk("gt_clk",  b0.clk_o[2],  1'b1);
    b0.ena = 1'b1;

    // ch_en toggle with a pending load on ch3
    b0.load = 4'b1000; b0.div_val[63:48] = 16'd4;
    @(negedge clk);
    b0.load = '0;
    chk("ce_pend1", b0.pend_o[3], 1'b1);
    b0.ch_en[3] = 1'b0;
    for (int j = 1; j <= 3; j++) begin
      @(negedge clk);
      chk("ce_pend0", b0.pend_o[3], 1'b0);
      chk("ce_clk",   b0.clk_o[3],  1'b0);
      chk("ce_tick",  b0.tick_o[3], 1'b0);
    end
    b0.ch_en[3] = 1'b1;
    for (int j = 1; j <= 6; j++) begin
      @(negedge clk);
      chk("ce_rtick", b0.tick_o[3], (j == 5));
      chk("ce_rclk",  b0.clk_o[3],  (j >= 5));
    end

    // WIDTH=4, N=15: period 32, no wrap
    b1.ena = 1'b1;
    for (int j = 1; j <= 64; j++) begin
      @(negedge clk);
      chk("w4_tick", b1.tick_o, (j % 16 == 0));
      chk("w4_clk",  b1.clk_o,  ((j / 16) % 2 == 1));
    end
    chk("w4_pend", b1.pend_o, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/clk_divider_bank.md
# clk_divider_bank

Bank of `CHANNELS` independent programmable clock dividers in the peripheral unit, all sharing one global enable. Each channel has a `WIDTH`-bit terminal-count divider. It produces a single-cycle `tick` strobe every N+1 enabled cycles and a 50%-duty divided clock with period 2(N+1). Divide values are double-buffered and take effect only at a terminal count, so ratio changes are glitch-free. A `sync` input phase-aligns all channels.

## Interface
- `WIDTH`, 16: bit width of each divide value and of each channel counter.
- `CHANNELS`, 4: number of divider channels, ≥1.
- `RESET_DIV`, 1: divide value N loaded into the active and pending registers at reset; must fit in `WIDTH`.
- `clk`  in  1: single clock; all logic on posedge.
- `nrst`  in  1: asynchronous, active-low reset.
- `ena`  in  1: global enable. When low, every channel freezes.
- `sync`  in  1: synchronous phase-align pulse, applies to all channels.
- `ch_en`  in  CHANNELS: per-channel enable.
- `load`  in  CHANNELS: per-channel strobe that captures the divide value.
- `div_val`  in  CHANNELS*WIDTH: divide value N; channel i is `div_val[i*WIDTH +: WIDTH]`.
- `tick_o`  out  CHANNELS: registered one-cycle strobe at each terminal count.
- `clk_o`  out  CHANNELS: registered divided clock; toggles at each terminal count.
- `pend_o`  out  CHANNELS: high while a loaded value waits to become active.

## Operation
- Per-channel state:
  - `cnt` (WIDTH bits)
  - `active` N (WIDTH bits)
  - `pending` N (WIDTH bits)
  - `pend` flag
  - `clk_o`, `tick_o`
- Reset (`nrst` low, asynchronous):
  - `cnt`=0, `active`=`pending`=`RESET_DIV`.
  - `pend`=0, `clk_o`=0, `tick_o`=0.
- `load[i]` is honoured on any edge, regardless of `ena`, `sync` or `ch_en`:
  - `pending` ← `div_val` slice.
  - `pend` ← 1.
- Terminal count. On an edge with `ena`=1, `ch_en[i]`=1, `sync`=0 and `cnt`==`active`:
  - `cnt` ← 0, `tick_o` ← 1, `clk_o` ← ~`clk_o`.
  - If `pend` is set: `active` ← `pending`, `pend` ← 0.
- Otherwise, with `ena`=1 and `ch_en[i]`=1: `cnt` ← `cnt`+1 and `tick_o` ← 0.
- `ch_en[i]`=0 (with `ena`=1):
  - `cnt`=0, `clk_o`=0, `tick_o`=0.
  - A pending value is applied immediately (`active` ← `pending`, `pend` ← 0).
- `sync`=1 (with `ena`=1):
  - Every channel gets `cnt`=0, `clk_o`=0, `tick_o`=0.
  - Pending values are applied as for a disabled channel.
  - `sync` has priority over counting and over terminal count.
- `ena`=0:
  - `cnt`, `clk_o`, `active` and `pend` hold.
  - `tick_o` is forced 0 on the next edge.
  - `sync` is ignored.
  - `load` still captures.
- Simultaneous `load` and terminal count on the same edge:
  - Terminal count applies the `pending` value held before that edge, if `pend` was set.
  - The new value is captured into `pending` with `pend`=1.
  - The new value becomes active at the following terminal count.
- `active` changes only when `cnt` becomes 0, so `cnt` never exceeds `active`. No wrap-around is possible; the counter never wraps past 2^WIDTH−1.
- N=0: `tick_o` is high on every enabled cycle and `clk_o` = clk/2.
- N=2^WIDTH−1 is legal: period 2^WIDTH cycles.

## Timing
- All outputs are registered; no combinational input-to-output path.
- From the first enabled edge with `cnt`=0, `tick_o` is high in the cycle after the (N+1)-th enabled edge. The tick repeats every N+1 enabled cycles.
- `clk_o` period is 2(N+1) enabled cycles at exactly 50% duty. The rising edge of `clk_o` coincides with an odd-numbered tick (1st, 3rd, …).
- `pend_o` rises the cycle after `load` and falls the cycle after the terminal count that applies the value.
- Channels are mutually independent except for the shared `ena` and `sync`.
- Reset deassertion needs no synchronisation inside this block; the reset synchroniser lives upstream.

## Test plan
- Reset and free-run: hold `nrst` low, then release with `RESET_DIV`=1 and `ch_en`=all ones.
  - During reset: all outputs 0.
  - After release: `tick_o` high every 2nd cycle; `clk_o` period 4 cycles.
- Glitch-free reload: ch0 running N=3; pulse `load[0]` with N=5 at `cnt`=1.
  - `pend_o[0]`=1 until the next tick.
  - That tick period stays 4 cycles; subsequent periods are 6 cycles; no short `clk_o` pulse.
- Same-edge load: `load` coincides with terminal count while `pend`=0.
  - New N applies one period later.
  - `pend_o` stays high across one full old period.
- Gating: drop `ena` mid-count for 7 cycles.
  - `cnt`/`clk_o` hold; `tick_o`=0.
  - On resume, the tick arrives exactly (remaining count) cycles later.
  - `sync` pulsed during the `ena`=0 window has no effect.
- Phase align: ch0 N=2, ch1 N=5 free-running out of phase; pulse `sync`.
  - Both `clk_o`=0 and `cnt`=0 on the next edge.
  - Ticks coincide every 6 cycles thereafter.
- Extremes: N=0 gives continuous `tick_o` and clk/2. With `WIDTH`=4 and N=15, period is 32 cycles with no wrap.
- `ch_en` toggle: deassert with a pending load, then reassert.
  - Value applied immediately and `pend_o`=0.
  - Counting restarts from 0 with `clk_o`=0.
